// File: rtl/reg_write_buffer.sv
// reg_write_buffer: small FIFO of register write/clear commands.
// It drains one command per cycle onto the Register's write/writeEnable/clear inputs.
module reg_write_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_clr,
    output logic                   in_ready,
    input  logic                   hold,
    output logic [WIDTH-1:0]       write,
    output logic                   writeEnable,
    output logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop_err
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] write_q, write_d;
    logic             we_q, we_d, clr_q, clr_d, drop_q, drop_d;
    logic             push, pop;
    logic [WIDTH:0]   head;

    assign in_ready    = count_q != (AW+1)'(DEPTH);
    assign push        = in_valid & in_ready;
    assign pop         = (count_q != '0) & ~hold;
    assign head        = mem_q[rd_ptr_q];
    assign write       = write_q;
    assign writeEnable = we_q;
    assign clear       = clr_q;
    assign count       = count_q;
    assign drop_err    = drop_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = (push & ~pop) ? count_q + (AW+1)'(1) :
                   (pop & ~push) ? count_q - (AW+1)'(1) : count_q;
        write_d  = pop ? (head[WIDTH] ? '0 : head[WIDTH-1:0]) : write_q;
        we_d     = pop & ~head[WIDTH];
        clr_d    = pop & head[WIDTH];
        drop_d   = drop_q | (in_valid & ~in_ready);
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            write_q  <= '0;
            we_q     <= 1'b0;
            clr_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            write_q  <= write_d;
            we_q     <= we_d;
            clr_q    <= clr_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: a flush zeroes the pointers and count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_clr, in_data};
    end
endmodule

// File: tb/tb_reg_write_buffer.sv
// tb_reg_write_buffer: directed stimulus with a scoreboard of expected issued commands.
module tb_reg_write_buffer;
    localparam int W = 32;
    localparam int D = 4;
    logic         clk = 1'b0;
    logic         clear_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_clr = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, writeEnable, clear, drop_err;
    logic [W-1:0] write;
    logic [2:0]   count;
    logic [W:0]   sb [$];
    logic [W:0]   exp_e;
    bit           mon_en = 1'b0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    reg_write_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_data(in_data),
        .in_clr(in_clr), .in_ready(in_ready), .hold(hold), .write(write),
        .writeEnable(writeEnable), .clear(clear), .count(count), .drop_err(drop_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ent(input logic c, input logic [W-1:0] d);
        return c ? {1'b1, {W{1'b0}}} : {1'b0, d};
    endfunction

    // Every strobe must match the oldest outstanding expected command.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("we_and_clr", {63'd0, writeEnable & clear}, 64'd0);
            if (writeEnable || clear) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, writeEnable, clear, write}, 64'd0);
                end else begin
                    exp_e = sb.pop_front();
                    chk("issue", {31'd0, clear, write}, {31'd0, exp_e});
                    chk("issue_we", {63'd0, writeEnable}, {63'd0, ~exp_e[W]});
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic c, input logic [W-1:0] d, input bit acc);
        in_valid = 1'b1;
        in_clr   = c;
        in_data  = d;
        if (acc) sb.push_back(ent(c, d));
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // 1: reset with in_valid asserted
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h1234;
        step();
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_we", {63'd0, writeEnable}, 64'd0);
        chk("rst_clr", {63'd0, clear}, 64'd0);
        chk("rst_drop", {63'd0, drop_err}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_write", {32'd0, write}, 64'd0);
        in_valid = 1'b0;
        clear_n  = 1'b1;
        mon_en   = 1'b1;
        // 2: single write, one-cycle latency, no bypass
        drive(1'b0, 32'hAAAAAAAA, 1'b1);
        chk("t2_count1", {61'd0, count}, 64'd1);
        chk("t2_nobypass", {63'd0, writeEnable}, 64'd0);
        step();
        chk("t2_we", {63'd0, writeEnable}, 64'd1);
        chk("t2_write", {32'd0, write}, 64'hAAAAAAAA);
        chk("t2_count0", {61'd0, count}, 64'd0);
        step();
        chk("t2_we_off", {63'd0, writeEnable}, 64'd0);
        chk("t2_write_hold", {32'd0, write}, 64'hAAAAAAAA);
        // 3: fill under hold, overflow, drain without gaps
        hold = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h11 * (i + 1), 1'b1);
        chk("t3_full", {61'd0, count}, 64'd4);
        chk("t3_ready0", {63'd0, in_ready}, 64'd0);
        chk("t3_nodrop", {63'd0, drop_err}, 64'd0);
        chk("t3_held", {63'd0, writeEnable}, 64'd0);
        drive(1'b0, 32'h55, 1'b0);
        chk("t3_drop", {63'd0, drop_err}, 64'd1);
        chk("t3_count_kept", {61'd0, count}, 64'd4);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_drain_we", {63'd0, writeEnable}, 64'd1);
            chk("t3_drain_data", {32'd0, write}, 64'h11 * (i + 1));
        end
        chk("t3_empty", {61'd0, count}, 64'd0);
        step();
        chk("t3_we_off", {63'd0, writeEnable}, 64'd0);
        // 4: write 5, clear, write 7 back to back
        drive(1'b0, 32'd5, 1'b1);
        drive(1'b1, 32'hDEAD, 1'b1);
        chk("t4_we5", {63'd0, writeEnable}, 64'd1);
        chk("t4_w5", {32'd0, write}, 64'd5);
        drive(1'b0, 32'd7, 1'b1);
        chk("t4_clr", {63'd0, clear}, 64'd1);
        chk("t4_clr_we", {63'd0, writeEnable}, 64'd0);
        chk("t4_w0", {32'd0, write}, 64'd0);
        step();
        chk("t4_we7", {63'd0, writeEnable}, 64'd1);
        chk("t4_w7", {32'd0, write}, 64'd7);
        step();
        chk("t4_idle", {62'd0, writeEnable, clear}, 64'd0);
        // 5: steady push+pop at count 2, pointers wrap
        hold = 1'b1;
        drive(1'b0, 32'd100, 1'b1);
        drive(1'b0, 32'd101, 1'b1);
        chk("t5_count2", {61'd0, count}, 64'd2);
        hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_clr   = 1'b0;
            in_data  = 32'd200 + i;
            sb.push_back(ent(1'b0, 32'd200 + i));
            step();
            chk("t5_steady", {61'd0, count}, 64'd2);
            chk("t5_we", {63'd0, writeEnable}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        step();
        chk("t5_drained", {61'd0, count}, 64'd0);
        chk("t5_sticky", {63'd0, drop_err}, 64'd1);
        step();
        // 6: reset flushes queued entries, no stale data afterwards
        hold = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 32'hBAD0 + i, 1'b1);
        chk("t6_count3", {61'd0, count}, 64'd3);
        clear_n = 1'b0;
        step();
        sb.delete();
        chk("t6_count0", {61'd0, count}, 64'd0);
        chk("t6_strobes", {62'd0, writeEnable, clear}, 64'd0);
        chk("t6_drop", {63'd0, drop_err}, 64'd0);
        chk("t6_write", {32'd0, write}, 64'd0);
        clear_n = 1'b1;
        hold    = 1'b0;
        drive(1'b0, 32'd9, 1'b1);
        step();
        chk("t6_we9", {63'd0, writeEnable}, 64'd1);
        chk("t6_w9", {32'd0, write}, 64'd9);
        step();
        step();
        chk("t6_idle", {62'd0, writeEnable, clear}, 64'd0);
        chk("t6_final_count", {61'd0, count}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
